// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer and its FIFO.
package uart_pkg;

  localparam int UART_TXBUF_DEPTH_LOG2_DEFAULT = 4;
  localparam int UART_BYTE_W                   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer / line-side handshake bundle for uart_tx_buffer.
// The master side is the producer plus the uart_byte_tx it feeds; the slave side is the buffer.
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = uart_pkg::UART_TXBUF_DEPTH_LOG2_DEFAULT
) ();
  import uart_pkg::*;

  logic [UART_BYTE_W-1:0] wr_data;
  logic                   wr_en;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   send_go;
  logic                   tx_done;
  logic                   full;
  logic                   empty;
  logic [DEPTH_LOG2:0]    count;
  logic                   overflow;
  logic                   ovf_clr;

  modport master (
    output wr_data, wr_en, tx_done, ovf_clr,
    input  tx_data, send_go, full, empty, count, overflow
  );

  modport slave (
    input  wr_data, wr_en, tx_done, ovf_clr,
    output tx_data, send_go, full, empty, count, overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with registered full/empty/count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_BYTE_W,
  parameter int DEPTH_LOG2 = UART_TXBUF_DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   count_next;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Next occupancy; full/empty are derived from it so they are registered alongside count.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Queues bytes from a producer and hands them one at a time to uart_byte_tx.
//
// state | meaning
// IDLE  | waiting for a queued byte; pops the head as soon as one is present
// SEND  | send_go held high with tx_data stable until tx_done
// GAP   | one cycle with send_go low so uart_byte_tx can re-arm
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_TXBUF_DEPTH_LOG2_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_buffer_if.slave  bus
);

  tx_state_t              state;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   send_go;
  logic                   overflow;
  logic [UART_BYTE_W-1:0] fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DEPTH_LOG2:0]    fifo_count;
  logic                   pop_req;
  logic                   drop;

  // The pop decision comes straight from registered state, so the FIFO sees it the same cycle.
  assign pop_req = (state == IDLE) && !fifo_empty;
  assign drop    = bus.wr_en && fifo_full && !pop_req;

  uart_sync_fifo #(
    .WIDTH      (UART_BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (pop_req),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Send controller with registered tx_data/send_go.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_data <= '0;
      send_go <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_req) begin
            tx_data <= fifo_dout;
            send_go <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_done) begin
            send_go <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          send_go <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)            overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (bus.ovf_clr) overflow <= 1'b0;
  end

  assign bus.tx_data  = tx_data;
  assign bus.send_go  = send_go;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: single byte, burst, fill/overflow,
// write+pop at full, overflow clear and reset during a send.
module tb_uart_tx_buffer;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   failed    = 0;

  uart_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Acts as uart_byte_tx for one frame: waits for send_go, checks the byte,
  // holds a short frame, pulses tx_done. n counts low cycles since the last fall.
  task automatic serve(input logic [7:0] exp, input bit chk_gap, input string tag);
    int n;
    n = 0;
    while (bus.send_go !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_go"}, 32'(bus.send_go), 32'd1);
    if (chk_gap) check({tag, "_gap"}, 32'(n), 32'd2);
    check({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
    repeat (3) step();
    check({tag, "_hold"}, {23'd0, bus.send_go, bus.tx_data}, {23'd0, 1'b1, exp});
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check({tag, "_fall"}, 32'(bus.send_go), 32'd0);
  endtask

  initial begin
    int peak;
    bus.wr_data = 8'h00;
    bus.wr_en   = 1'b0;
    bus.tx_done = 1'b0;
    bus.ovf_clr = 1'b0;
    reset       = 1'b1;
    step();
    step();
    check("rst_send_go", 32'(bus.send_go), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    step();

    // Spurious tx_done while idle and empty
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("spur_idle", 32'(bus.send_go), 32'd0);

    // Single byte
    write_byte(8'hA5);
    check("single_cnt1", 32'(bus.count), 32'd1);
    check("single_nempty", 32'(bus.empty), 32'd0);
    check("single_go_early", 32'(bus.send_go), 32'd0);
    step();
    check("single_go", 32'(bus.send_go), 32'd1);
    check("single_data", 32'(bus.tx_data), 32'hA5);
    check("single_empty", 32'(bus.empty), 32'd1);
    serve(8'hA5, 1'b0, "single");
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    step();
    check("single_after_go", 32'(bus.send_go), 32'd0);
    check("single_after_empty", 32'(bus.empty), 32'd1);

    // Burst of five bytes on consecutive cycles
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      write_byte(8'(i + 1));
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    check("burst_peak", 32'(peak), 32'd4);
    serve(8'h01, 1'b0, "burst1");
    for (int i = 2; i <= 5; i++) serve(8'(i), 1'b1, $sformatf("burst%0d", i));
    step();
    step();
    check("burst_empty", 32'(bus.empty), 32'd1);
    check("burst_idle", 32'(bus.send_go), 32'd0);

    // Fill to full: 0x10 goes in flight, 0x11..0x20 queue up
    for (int i = 0; i < 17; i++) write_byte(8'(8'h10 + i));
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_ovf", 32'(bus.overflow), 32'd0);
    check("fill_inflight", {23'd0, bus.send_go, bus.tx_data}, {23'd0, 1'b1, 8'h10});
    write_byte(8'h21);
    check("drop_ovf", 32'(bus.overflow), 32'd1);
    check("drop_count", 32'(bus.count), 32'd16);

    // Overflow clear
    bus.ovf_clr = 1'b1;
    write_byte(8'h22);
    bus.ovf_clr = 1'b0;
    check("clr_and_set", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("clr_alone", 32'(bus.overflow), 32'd0);

    // Write and pop in the same cycle at full
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("wp_gap_go", 32'(bus.send_go), 32'd0);
    step();
    check("wp_idle_full", 32'(bus.full), 32'd1);
    write_byte(8'h77);
    check("wp_count", 32'(bus.count), 32'd16);
    check("wp_full", 32'(bus.full), 32'd1);
    check("wp_ovf", 32'(bus.overflow), 32'd0);
    serve(8'h11, 1'b0, "wp11");
    for (int i = 8'h12; i <= 8'h20; i++) serve(8'(i), 1'b1, $sformatf("drain%0h", i));
    serve(8'h77, 1'b1, "last77");
    step();
    step();
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);

    // Reset in SEND with three bytes queued
    for (int i = 0; i < 4; i++) write_byte(8'(8'hA0 + i));
    check("pre_rst_count", 32'(bus.count), 32'd3);
    check("pre_rst_go", 32'(bus.send_go), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_go", 32'(bus.send_go), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_data", 32'(bus.tx_data), 32'h00);
    reset = 1'b0;
    repeat (10) step();
    check("post_rst_go", 32'(bus.send_go), 32'd0);
    check("post_rst_empty", 32'(bus.empty), 32'd1);
    write_byte(8'h5A);
    step();
    check("post_rst_new_go", 32'(bus.send_go), 32'd1);
    serve(8'h5A, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and send controller sitting directly upstream of `uart_byte_tx`. Accepts bytes from a producer (typically the `Rx_done`/`uart_Data` pair of `uart_byte_rx`, or a CPU write strobe). Queues them and drives the `Data`/`Send_Go`/`Tx_done` handshake of `uart_byte_tx` one byte at a time. Bursts arriving faster than the line rate are therefore not lost.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries; legal range 1..8.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: single-cycle enqueue strobe; `wr_data` is sampled on the same edge.
- `tx_data` out 8: byte presented to `uart_byte_tx.Data`.
- `send_go` out 1: drives `uart_byte_tx.Send_Go`.
- `tx_done` in 1: from `uart_byte_tx.Tx_done`; single-cycle pulse at end of stop bit.
- `full` out 1: FIFO holds 2**DEPTH_LOG2 entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2**DEPTH_LOG2.
- `overflow` out 1: sticky flag; set when a write is dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- **Reset values:** `tx_data`=8'h00, `send_go`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, state=IDLE, pointers=0.
- **FIFO:**
  - Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth.
  - `count` is tracked separately and is DEPTH_LOG2+1 bits wide.
- **Write:** `wr_en` with !`full` stores `wr_data` at the write pointer and increments the pointer.
- **Write to full FIFO:**
  - The byte is dropped and `overflow` is set.
  - Exception: when a pop happens in the same cycle, the write is accepted. `count` stays unchanged and `overflow` stays 0.
- **Overflow flag:**
  - `ovf_clr` clears `overflow`.
  - A set and a clear in the same cycle leave `overflow`=1 (set wins).
- **Controller FSM:**
  - IDLE: if !`empty`, pop head into `tx_data`, set `send_go`=1, go to SEND. Otherwise stay in IDLE.
  - SEND: `send_go` held 1 and `tx_data` held stable. On `tx_done`=1, set `send_go`=0 and go to GAP.
  - GAP: one cycle with `send_go`=0, which lets `uart_byte_tx` re-arm. Then go to IDLE.
- **Spurious `tx_done`:** a `tx_done` pulse in IDLE or GAP is ignored.
- **Simultaneous write and pop:**
  - With `count`=0: the pop is not possible (`empty`=1). The write lands and is popped on a later IDLE cycle.
  - Otherwise both take effect and `count` is unchanged.
- **Reset mid-transmission:**
  - Queue is flushed and `send_go` falls on the next edge.
  - The byte in progress on the line is the concern of `uart_byte_tx`'s own reset.

## Timing
- **Write visibility:** `wr_en` sampled at edge N. At N+1, `count` has incremented and `empty` has deasserted.
- **Write to first send:** from an empty, IDLE block, `wr_en` at edge N gives the pop and `send_go`=1 registered at edge N+1. `send_go` is therefore visible in the cycle after the write is captured, i.e. two edges after `wr_en` is presented.
- **Back-to-back bytes:**
  - `tx_done` sampled at edge T.
  - `send_go`=0 from T (GAP state).
  - IDLE at T+1.
  - Next byte popped with `send_go`=1 at T+2.
  - Minimum low time of `send_go` between bytes: 2 cycles.
- **Status outputs:** all outputs are registered; `full`, `empty` and `count` update on the edge that changes occupancy.
- **Throughput:** one byte per UART frame plus 2 clk cycles.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state typedef: IDLE, SEND, GAP.
  - `UART_TXBUF_DEPTH_LOG2_DEFAULT`=4.
  - `UART_BYTE_W`=8.
- **Sub-module `uart_sync_fifo`:**
  - Parameterised width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Intended for reuse as the RX-side buffer.
- **`uart_tx_buffer`:** instantiates `uart_sync_fifo` and contains only the FSM and the overflow logic.

## Test plan
- **Single byte:** write 8'hA5 after reset → `send_go` rises 2 edges after `wr_en` with `tx_data`=8'hA5, held until `tx_done`. `send_go` is low on the next edge; `empty`=1 afterwards.
- **Burst of 5 bytes:**
  - Stimulus: 8'h01..8'h05 on consecutive cycles, with a `uart_byte_tx` model.
  - Required response: bytes leave in order 01..05, each `send_go` low gap is ≥2 cycles, and `count` peaks at 4 (the first byte is popped at once).
- **Fill to full, DEPTH_LOG2=4:**
  - Stimulus: hold `tx_done` low and write 17 bytes (0x10..0x20).
  - Expected state: 0x10 is in flight; the FIFO takes 16 more (0x11..0x20), so `count`=16, `full`=1 and `overflow` stays 0.
  - Stimulus: write 0x21.
  - Required response: the byte is dropped, `overflow`=1 and `count` stays 16.
- **Write and pop in the same cycle at full:**
  - Stimulus: with `full`=1, pulse `tx_done`. At the IDLE pop cycle, write 8'h77.
  - Required response: `count` stays 16, `overflow` unchanged, and 8'h77 is later emitted last.
- **Overflow clear:** `ovf_clr` and a dropped write in the same cycle → `overflow` stays 1. A lone `ovf_clr` → `overflow`=0.
- **Reset mid-send:**
  - Stimulus: assert `reset` while in SEND with 3 bytes queued.
  - Required response: next edge gives `send_go`=0, `count`=0, `empty`=1, `tx_data`=8'h00. No byte is sent after reset is released until a new write.
